button_event_scheduler: RTL and testbench

- Front end for the guessing-game button bank. Registers N_BTN button inputs and detects the selected edge type on each channel.
- Applies a per-channel lockout so switch bounce does not produce repeat events, and holds one pending event per channel.
- Shares a single event output between channels using round-robin priority and a valid/ready handshake.
- Game FSM consumes evt_id; the edge-detect resource is time-shared into one event stream.

---
 rtl/game_pkg.sv | 18 +
 rtl/rr_pick.sv | 33 +++
 rtl/button_event_scheduler.sv | 113 +++++++++++
 tb/tb_button_event_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the guessing-game button front end.
package game_pkg;

    typedef enum logic [1:0] {
        DET_RISE = 2'b00,
        DET_FALL = 2'b01,
        DET_BOTH = 2'b10,
        DET_NONE = 2'b11
    } det_type_e;

    // A counter that must hold the value `cycles` needs at least one bit even when cycles is 0.
    function automatic int lock_w(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping at N_BTN.
module rr_pick
    import game_pkg::*;
#(
    parameter int N_BTN = 4,
    parameter int ID_W  = $clog2(N_BTN)
) (
    input  logic [N_BTN-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_any
);

    int              k;
    logic [ID_W-1:0] idx;

    // Walk the distance from ptr downward so the nearest request overwrites farther ones.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        k       = 0;
        idx     = '0;
        for (int j = N_BTN - 1; j >= 0; j--) begin
            k   = (int'(ptr) + j) % N_BTN;
            idx = ID_W'(k);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Button bank front end: edge detect with per-channel lockout, one pending event per
// channel, and a single round-robin arbitrated valid/ready event output.
module button_event_scheduler
    import game_pkg::*;
#(
    parameter int         N_BTN          = 4,
    parameter logic [1:0] DETECT_TYPE    = 2'b00,
    parameter int         LOCKOUT_CYCLES = 8,
    parameter int         ID_W           = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             flush,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_BTN-1:0] pending,
    output logic             overflow
);

    localparam int                LOCK_W    = lock_w(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);

    logic [N_BTN-1:0]  ff0;
    logic [N_BTN-1:0]  ff1;
    logic [LOCK_W-1:0] lock_cnt [N_BTN];
    logic [ID_W-1:0]   rr_ptr;

    logic [N_BTN-1:0]  det;
    logic [N_BTN-1:0]  accept;
    logic [N_BTN-1:0]  granted;
    logic [N_BTN-1:0]  lost;
    logic [N_BTN-1:0]  pending_next;

    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              slot_free;
    logic              grant;

    function automatic logic edge_sel(input logic cur, input logic prev);
        case (DETECT_TYPE)
            DET_RISE: return cur & ~prev;
            DET_FALL: return ~cur & prev;
            DET_BOTH: return cur ^ prev;
            default:  return 1'b0;
        endcase
    endfunction

    assign slot_free = ~evt_valid | evt_ready;
    assign grant     = slot_free & gnt_any;

    rr_pick #(
        .N_BTN (N_BTN),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req     (pending),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // A fresh edge on the channel being granted re-arms pending instead of being lost.
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        assign det[i]          = edge_sel(ff0[i], ff1[i]);
        assign accept[i]       = det[i] && (lock_cnt[i] == '0);
        assign granted[i]      = grant && (gnt_idx == ID_W'(i));
        assign lost[i]         = accept[i] && pending[i] && !granted[i];
        assign pending_next[i] = accept[i] ? 1'b1 : (granted[i] ? 1'b0 : pending[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff0       <= '0;
            ff1       <= '0;
            rr_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            overflow  <= 1'b0;
            pending   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                lock_cnt[i] <= '0;
            end
        end else begin
            ff0 <= btn_in;
            ff1 <= ff0;
            // Lockout keeps counting through flush so bounce after a flush is still masked.
            for (int i = 0; i < N_BTN; i++) begin
                if (accept[i]) begin
                    lock_cnt[i] <= LOCK_LOAD;
                end else if (lock_cnt[i] != '0) begin
                    lock_cnt[i] <= lock_cnt[i] - 1'b1;
                end
            end
            if (flush) begin
                pending   <= '0;
                evt_valid <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                pending  <= pending_next;
                overflow <= |lost;
                if (grant) begin
                    evt_valid <= 1'b1;
                    evt_id    <= gnt_idx;
                    rr_ptr    <= (gnt_idx == ID_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
                end else if (slot_free) begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed vector table, hand sequences, random vs model.
module tb_button_event_scheduler;

    localparam int N    = 4;
    localparam int LOCK = 3;
    localparam int DET  = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_in;
    logic       flush;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    button_event_scheduler #(
        .N_BTN          (N),
        .DETECT_TYPE    (2'b00),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .flush     (flush),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] p, input logic o);
        chk({tag, " valid"}, 32'(evt_valid), 32'(v));
        chk({tag, " pending"}, 32'(pending), 32'(p));
        chk({tag, " overflow"}, 32'(overflow), 32'(o));
        if (v) chk({tag, " id"}, 32'(evt_id), 32'(id));
    endtask

    task automatic cyc(input logic [3:0] b, input logic f, input logic rdy);
        btn_in    = b;
        flush     = f;
        evt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic [3:0] exp_pend;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] b, input logic v, input logic [1:0] id,
                       input logic [3:0] p, input logic o);
        vec_t r;
        r.btn = b; r.ready = 1'b1; r.exp_valid = v; r.exp_id = id; r.exp_pend = p; r.exp_ovf = o;
        tbl.push_back(r);
    endtask

    // Reference model: levels seen on the last two cycles, remaining lockout per channel,
    // pending flags, the output slot and the next channel to favour.
    bit m_cur[N], m_prev[N], m_pend[N];
    int m_lock[N];
    bit m_valid, m_ovf;
    int m_id, m_ptr;

    function automatic bit is_edge(input bit cur, input bit prev);
        case (DET)
            0: return cur && !prev;
            1: return !cur && prev;
            2: return cur != prev;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic [3:0] b, input bit r, input bit f, input bit rdy);
        bit nxt[N];
        bit free, hit, ovf;
        int k;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_cur[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_lock[i] = 0;
            end
            m_valid = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
            return;
        end
        free = !m_valid || rdy;
        hit  = 0;
        k    = 0;
        if (free) begin
            for (int j = 0; j < N; j++) begin
                if (!hit && m_pend[(m_ptr + j) % N]) begin
                    hit = 1;
                    k   = (m_ptr + j) % N;
                end
            end
        end
        ovf = 0;
        for (int i = 0; i < N; i++) begin
            nxt[i] = m_pend[i];
            if (hit && k == i) nxt[i] = 0;
            if (is_edge(m_cur[i], m_prev[i]) && m_lock[i] == 0) begin
                if (m_pend[i] && !(hit && k == i)) ovf = 1;
                nxt[i]    = 1;
                m_lock[i] = LOCK;
            end else if (m_lock[i] > 0) begin
                m_lock[i]--;
            end
        end
        if (f) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_valid = 0;
            m_ovf   = 0;
        end else begin
            for (int i = 0; i < N; i++) m_pend[i] = nxt[i];
            m_ovf = ovf;
            if (hit) begin
                m_valid = 1;
                m_id    = k;
                m_ptr   = (k + 1) % N;
            end else if (free) begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_prev[i] = m_cur[i];
            m_cur[i]  = b[i];
        end
    endtask

    initial begin
        logic [3:0] mp;
        logic [3:0] rb;
        bit         rr, rf, ry;

        rst = 1'b1; btn_in = 4'b0000; flush = 1'b0; evt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        chk("reset id", 32'(evt_id), 32'd0);
        rst = 1'b0;

        // Idle, single press on ch2, rotation, bounce on ch1.
        repeat (10) add(4'b0000, 0, 0, 4'b0000, 0);
        add(4'b0100, 0, 0, 4'b0000, 0);
        add(4'b0100, 0, 0, 4'b0100, 0);
        add(4'b0100, 1, 2, 4'b0000, 0);
        add(4'b0100, 0, 0, 4'b0000, 0);
        repeat (5) add(4'b0000, 0, 0, 4'b0000, 0);
        add(4'b0001, 0, 0, 4'b0000, 0);
        add(4'b0001, 0, 0, 4'b0001, 0);
        add(4'b0001, 1, 0, 4'b0000, 0);
        add(4'b0001, 0, 0, 4'b0000, 0);
        repeat (5) add(4'b0000, 0, 0, 4'b0000, 0);
        add(4'b0011, 0, 0, 4'b0000, 0);
        add(4'b0011, 0, 0, 4'b0011, 0);
        add(4'b0011, 1, 1, 4'b0001, 0);
        add(4'b0011, 1, 0, 4'b0000, 0);
        add(4'b0011, 0, 0, 4'b0000, 0);
        repeat (5) add(4'b0000, 0, 0, 4'b0000, 0);
        add(4'b0010, 0, 0, 4'b0000, 0);
        add(4'b0000, 0, 0, 4'b0010, 0);
        add(4'b0010, 1, 1, 4'b0000, 0);
        add(4'b0010, 0, 0, 4'b0000, 0);
        add(4'b0010, 0, 0, 4'b0000, 0);
        repeat (5) add(4'b0000, 0, 0, 4'b0000, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            cyc(tbl[r].btn, 1'b0, tbl[r].ready);
            chk_out($sformatf("tbl%0d", r), tbl[r].exp_valid, tbl[r].exp_id,
                    tbl[r].exp_pend, tbl[r].exp_ovf);
        end

        // Backpressure on ch3: slot, then pending, then overflow.
        cyc(4'b1000, 0, 0); cyc(4'b1000, 0, 0);
        chk_out("bp a2", 0, 0, 4'b1000, 0);
        cyc(4'b0000, 0, 0);
        chk_out("bp a3", 1, 3, 4'b0000, 0);
        cyc(4'b0000, 0, 0); cyc(4'b0000, 0, 0);
        chk_out("bp a5", 1, 3, 4'b0000, 0);
        cyc(4'b1000, 0, 0); cyc(4'b1000, 0, 0);
        chk_out("bp b2", 1, 3, 4'b1000, 0);
        cyc(4'b0000, 0, 0); cyc(4'b0000, 0, 0); cyc(4'b0000, 0, 0);
        chk_out("bp b5", 1, 3, 4'b1000, 0);
        cyc(4'b1000, 0, 0); cyc(4'b1000, 0, 0);
        chk_out("bp c2", 1, 3, 4'b1000, 1);
        cyc(4'b0000, 0, 0);
        chk_out("bp c3", 1, 3, 4'b1000, 0);
        cyc(4'b0000, 0, 1);
        chk_out("bp d1", 1, 3, 4'b0000, 0);
        cyc(4'b0000, 0, 1);
        chk_out("bp d2", 0, 0, 4'b0000, 0);
        cyc(4'b0000, 0, 1);
        chk_out("bp d3", 0, 0, 4'b0000, 0);

        // Flush with a held event and two pending channels.
        cyc(4'b0100, 0, 0); cyc(4'b0100, 0, 0); cyc(4'b0100, 0, 0);
        chk_out("fl e3", 1, 2, 4'b0000, 0);
        cyc(4'b0111, 0, 0); cyc(4'b0111, 0, 0);
        chk_out("fl e5", 1, 2, 4'b0011, 0);
        cyc(4'b0111, 1, 0);
        chk_out("fl f", 0, 0, 4'b0000, 0);
        repeat (4) cyc(4'b0000, 0, 1);
        cyc(4'b0001, 0, 1); cyc(4'b0001, 0, 1);
        chk_out("fl g2", 0, 0, 4'b0001, 0);
        cyc(4'b0001, 0, 1);
        chk_out("fl g3", 1, 0, 4'b0000, 0);
        repeat (5) cyc(4'b0000, 0, 1);

        // Reset mid-operation drops queued events; buttons held high re-fire afterwards.
        cyc(4'b0010, 0, 0); cyc(4'b0010, 0, 0); cyc(4'b0110, 0, 0); cyc(4'b0110, 0, 0);
        chk_out("mr pre", 1, 1, 4'b0100, 0);
        rst = 1'b1;
        cyc(4'b0110, 0, 0); cyc(4'b0110, 0, 0);
        chk_out("mr rst", 0, 0, 4'b0000, 0);
        rst = 1'b0;
        cyc(4'b0110, 0, 1);
        chk_out("mr r1", 0, 0, 4'b0000, 0);
        cyc(4'b0110, 0, 1);
        chk_out("mr r2", 0, 0, 4'b0110, 0);
        cyc(4'b0110, 0, 1);
        chk_out("mr r3", 1, 1, 4'b0100, 0);
        cyc(4'b0110, 0, 1);
        chk_out("mr r4", 1, 2, 4'b0000, 0);

        // Random traffic against the reference model, starting from a reset.
        rst = 1'b1;
        model_step(4'b0000, 1, 0, 0);
        cyc(4'b0000, 0, 0);
        rst = 1'b0;
        rb = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
            rr = ($urandom_range(0, 299) == 0);
            rf = ($urandom_range(0, 39) == 0);
            ry = ($urandom_range(0, 9) < 7);
            rst = rr;
            model_step(rb, rr, rf, ry);
            cyc(rb, rf, ry);
            for (int i = 0; i < N; i++) mp[i] = m_pend[i];
            chk_out($sformatf("rnd%0d", c), m_valid, 2'(m_id), mp, m_ovf);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
